// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: ROM markers, FSM encoding and OV7670 register addresses
package cam_cfg_pkg;
    localparam logic [15:0] ROM_END = 16'hFFFF;
    localparam logic [15:0] ROM_DLY = 16'hFFF0;

    localparam logic [3:0] PWRUP   = 4'd0;
    localparam logic [3:0] IDLE    = 4'd1;
    localparam logic [3:0] FETCH   = 4'd2;
    localparam logic [3:0] DECODE  = 4'd3;
    localparam logic [3:0] SEND    = 4'd4;
    localparam logic [3:0] WAIT_LO = 4'd5;
    localparam logic [3:0] WAIT_HI = 4'd6;
    localparam logic [3:0] DELAY   = 4'd7;
    localparam logic [3:0] DONE    = 4'd8;

    localparam logic [7:0] COM1   = 8'h04;
    localparam logic [7:0] COM3   = 8'h0C;
    localparam logic [7:0] CLKRC  = 8'h11;
    localparam logic [7:0] COM7   = 8'h12;
    localparam logic [7:0] COM9   = 8'h14;
    localparam logic [7:0] TSLB   = 8'h3A;
    localparam logic [7:0] COM13  = 8'h3D;
    localparam logic [7:0] COM15  = 8'h40;
    localparam logic [7:0] MTX1   = 8'h4F;
    localparam logic [7:0] MTX2   = 8'h50;
    localparam logic [7:0] MTX3   = 8'h51;
    localparam logic [7:0] MTX4   = 8'h52;
    localparam logic [7:0] MTX5   = 8'h53;
    localparam logic [7:0] MTX6   = 8'h54;
    localparam logic [7:0] MTXS   = 8'h58;
    localparam logic [7:0] RGB444 = 8'h8C;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } rom_entry_t;
endpackage

// File: rtl/cam_cfg_rom.sv
// cam_cfg_rom: synchronous-read OV7670 RGB444 register table
module cam_cfg_rom
    import cam_cfg_pkg::*;
#(
    parameter int ROM_AW     = 8,
    parameter bit TEST_TABLE = 1'b0
) (
    input  logic              i_clk,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [15:0]       o_q
);
    function automatic logic [15:0] entry(input int i);
        case (i)
            0:       entry = {COM7, 8'h80};
            1:       entry = ROM_DLY;
            2:       entry = {COM7, 8'h04};
            3:       entry = {RGB444, 8'h02};
            4:       entry = {COM1, 8'h00};
            5:       entry = {COM15, 8'hD0};
            6:       entry = {COM3, 8'h00};
            7:       entry = {CLKRC, 8'h01};
            8:       entry = {TSLB, 8'h04};
            9:       entry = {COM9, 8'h18};
            10:      entry = {MTX1, 8'hB3};
            11:      entry = {MTX2, 8'hB3};
            12:      entry = {MTX3, 8'h00};
            13:      entry = {MTX4, 8'h3D};
            14:      entry = {MTX5, 8'hA7};
            15:      entry = {MTX6, 8'hE4};
            16:      entry = {MTXS, 8'h9E};
            17:      entry = {COM13, 8'hC0};
            default: entry = ROM_END;
        endcase
    endfunction

    // The test table holds a write in every slot and no end marker
    always_ff @(posedge i_clk)
        o_q <= TEST_TABLE ? {8'h01 + 8'(i_addr), 8'hA0 + 8'(i_addr)} : entry(int'(i_addr));
endmodule

// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks the register ROM, issuing one SCCB write per entry
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int CLK_F      = 25_000_000,
    parameter int DELAY_MS   = 10,
    parameter int ROM_AW     = 8,
    parameter bit TEST_TABLE = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start,
    input  logic       i_sccb_ready,
    output logic       o_sccb_start,
    output logic [7:0] o_sccb_addr,
    output logic [7:0] o_sccb_data,
    output logic       o_busy,
    output logic       o_done
);
    localparam int DELAY_CYC = (CLK_F / 1000) * DELAY_MS;
    localparam int TW = $clog2(DELAY_CYC + 1);

    logic [3:0]        state;
    logic [ROM_AW-1:0] ptr;
    logic [TW-1:0]     timer;
    logic [15:0]       rom_q;
    rom_entry_t        ent;
    logic              last;
    logic              pwr_end;

    cam_cfg_rom #(.ROM_AW(ROM_AW), .TEST_TABLE(TEST_TABLE)) u_rom (
        .i_clk  (i_clk),
        .i_addr (ptr),
        .o_q    (rom_q)
    );

    assign ent = rom_q;
    assign last = &ptr;
    assign pwr_end = timer == TW'(DELAY_CYC - 1);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= PWRUP;
            ptr <= '0;
            timer <= '0;
            o_sccb_start <= 1'b0;
            o_sccb_addr <= '0;
            o_sccb_data <= '0;
            o_busy <= 1'b1;
            o_done <= 1'b0;
        end else begin
            o_sccb_start <= 1'b0;
            case (state)
                PWRUP: begin
                    timer <= pwr_end ? '0 : timer + 1'b1;
                    ptr <= '0;
                    if (pwr_end) state <= FETCH;
                end
                IDLE: if (i_start) begin
                    o_done <= 1'b0;
                    o_busy <= 1'b1;
                    ptr <= '0;
                    state <= FETCH;
                end
                FETCH: state <= DECODE;
                DECODE:
                    if (rom_q == ROM_END) state <= DONE;
                    else if (rom_q == ROM_DLY) begin
                        timer <= TW'(DELAY_CYC);
                        state <= DELAY;
                    end else begin
                        o_sccb_addr <= ent.addr;
                        o_sccb_data <= ent.data;
                        state <= SEND;
                    end
                SEND: if (i_sccb_ready) begin
                    o_sccb_start <= 1'b1;
                    state <= WAIT_LO;
                end
                WAIT_LO: if (!i_sccb_ready) state <= WAIT_HI;
                // The last slot finishes the sequence even without an end marker
                WAIT_HI: if (i_sccb_ready) begin
                    ptr <= last ? ptr : ptr + 1'b1;
                    state <= last ? DONE : FETCH;
                end
                DELAY: begin
                    timer <= timer - 1'b1;
                    if (timer == TW'(1)) begin
                        ptr <= last ? ptr : ptr + 1'b1;
                        state <= last ? DONE : FETCH;
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// tb_cam_cfg_sequencer: scoreboard bench with SCCB master models for two ROM variants
module tb_cam_cfg_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, start, ready, sstart, busy, done;
    logic [7:0] addr, data;
    logic       rstn_b, start_b, ready_b, sstart_b, busy_b, done_b;
    logic [7:0] addr_b, data_b;

    int total = 0, bad = 0;
    int cyc = 0;
    int lo_cyc = 20;
    int nwr = 0, nrdy = 0, nwr_b = 0;
    int start_cyc [256];
    int rdy_cyc [256];
    logic [15:0] exp_q [$];
    logic [15:0] exp_b [$];
    logic [15:0] tbl [17] = '{16'h1280, 16'h1204, 16'h8C02, 16'h0400, 16'h40D0, 16'h0C00,
                              16'h1101, 16'h3A04, 16'h1418, 16'h4FB3, 16'h50B3, 16'h5100,
                              16'h523D, 16'h53A7, 16'h54E4, 16'h589E, 16'h3DC0};

    cam_cfg_sequencer #(.CLK_F(1000), .DELAY_MS(10), .ROM_AW(8)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_sccb_ready(ready),
        .o_sccb_start(sstart), .o_sccb_addr(addr), .o_sccb_data(data),
        .o_busy(busy), .o_done(done)
    );

    cam_cfg_sequencer #(.CLK_F(1000), .DELAY_MS(10), .ROM_AW(3), .TEST_TABLE(1'b1)) dut_b (
        .i_clk(clk), .i_rstn(rstn_b), .i_start(start_b), .i_sccb_ready(ready_b),
        .o_sccb_start(sstart_b), .o_sccb_addr(addr_b), .o_sccb_data(data_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic push_table();
        for (int i = 0; i < 17; i++) exp_q.push_back(tbl[i]);
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 5000 && nwr < n; i++) @(negedge clk);
        check("writes_reached", nwr < n ? nwr : n, n);
    endtask

    task automatic wait_done(output int at, output logic pb);
        at = -1;
        pb = busy;
        for (int i = 0; i < 20000 && at < 0; i++) begin
            @(negedge clk);
            if (done) at = cyc;
            else pb = busy;
        end
        check("done_reached", int'(at >= 0), 1);
    endtask

    // Master A plus scoreboard monitor: ready drops on the start pulse, returns lo_cyc cycles later
    initial begin
        int cnt;
        logic [15:0] held;
        cnt = 0;
        held = '0;
        ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rstn && sstart) begin
                check("start_with_ready_high", ready, 1);
                if (exp_q.size() == 0) check("unexpected_write", {addr, data}, 0);
                else check($sformatf("write%0d", nwr), {addr, data}, exp_q.pop_front());
                start_cyc[nwr] = cyc;
                nwr++;
            end
            if (!rstn) begin
                ready = 1'b1;
                cnt = 0;
            end else if (cnt > 0) begin
                check("addr_data_hold", {addr, data}, held);
                cnt--;
                if (cnt == 0) begin
                    ready = 1'b1;
                    rdy_cyc[nrdy] = cyc;
                    nrdy++;
                end
            end else if (sstart) begin
                ready = 1'b0;
                cnt = lo_cyc;
                held = {addr, data};
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        ready_b = 1'b1;
        forever begin
            @(negedge clk);
            if (rstn_b && sstart_b) begin
                check("b_start_with_ready_high", ready_b, 1);
                if (exp_b.size() == 0) check("b_unexpected_write", {addr_b, data_b}, 0);
                else check($sformatf("b_write%0d", nwr_b), {addr_b, data_b}, exp_b.pop_front());
                nwr_b++;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) ready_b = 1'b1;
            end else if (sstart_b) begin
                ready_b = 1'b0;
                cnt = 5;
            end
        end
    end

    initial begin
        int base, rbase, t0, s0, at, r;
        logic pb;
        rstn = 1'b1; rstn_b = 1'b1; start = 1'b0; start_b = 1'b0;
        #2 rstn = 1'b0; rstn_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start", sstart, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);

        push_table();
        for (int i = 0; i < 8; i++) exp_b.push_back({8'(i + 1), 8'(8'hA0 + i)});
        base = nwr; rbase = nrdy; t0 = cyc;
        rstn = 1'b1; rstn_b = 1'b1;
        wait_writes(base + 1);
        check("pwrup_first_start_cycle", start_cyc[base] - t0, 13);
        wait_writes(base + 2);
        check("delay_gap_after_reset_write", start_cyc[base + 1] - rdy_cyc[rbase], 16);
        wait_writes(base + 5);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(at, pb);
        check("done_latency", at - rdy_cyc[nrdy - 1], 4);
        check("busy_before_done", pb, 1);
        check("busy_falls_with_done", busy, 0);
        check("run1_write_count", nwr - base, 17);
        check("run1_queue_empty", exp_q.size(), 0);
        check("b_done", done_b, 1);
        check("b_write_count", nwr_b, 8);

        lo_cyc = 500;
        push_table();
        base = nwr; rbase = nrdy;
        @(negedge clk) start = 1'b1;
        s0 = cyc;
        @(negedge clk) start = 1'b0;
        check("restart_done_clear", done, 0);
        check("restart_busy", busy, 1);
        wait_writes(base + 1);
        check("restart_first_start_cycle", start_cyc[base] - s0, 4);
        for (int i = 0; i < 20000 && nrdy - rbase < 17; i++) @(negedge clk);
        check("run2_ready_returns", nrdy - rbase, 17);
        r = rdy_cyc[nrdy - 1];
        while (cyc < r + 3) @(negedge clk);
        check("done_low_before_rise", done, 0);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("done_rise_with_start", done, 1);
        check("busy_fall_with_start", busy, 0);
        repeat (10) @(negedge clk);
        check("start_at_done_ignored_done", done, 1);
        check("start_at_done_ignored_busy", busy, 0);
        check("run2_write_count", nwr - base, 17);
        check("run2_queue_empty", exp_q.size(), 0);

        lo_cyc = 20;
        push_table();
        base = nwr;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_writes(base + 3);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_start", sstart, 0);
        check("arst_done", done, 0);
        check("arst_busy", busy, 1);
        check("arst_addr", addr, 0);
        check("arst_data", data, 0);
        exp_q.delete();
        push_table();
        repeat (2) @(negedge clk);
        base = nwr; t0 = cyc;
        rstn = 1'b1;
        wait_writes(base + 1);
        check("arst_pwrup_first_start_cycle", start_cyc[base] - t0, 13);
        wait_done(at, pb);
        check("run3_write_count", nwr - base, 17);
        check("run3_queue_empty", exp_q.size(), 0);

        check("b_no_wrap_count", nwr_b, 8);
        check("b_done_held", done_b, 1);
        check("b_busy_low", busy_b, 0);
        check("b_queue_empty", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
